// File: rtl/matrix_row_fetcher.sv
// rtl/matrix_row_fetcher.sv - Avalon-MM read master fetching a run of ROM rows into a valid/ready stream.
// Optional read watchdog enabled by defining FETCH_TIMEOUT_EN.
module matrix_row_fetcher #(
   parameter int ROW_W          = 64,
   parameter int ADDR_W         = 32,
   parameter int NUM_ROWS       = 8,
   parameter int TIMEOUT_CYCLES = 63
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [3:0]        cfg_count,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic [ROW_W-1:0]  avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest,
   output logic [ROW_W-1:0]  row_data,
   output logic [3:0]        row_idx,
   output logic              row_valid,
   input  logic              row_ready,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DATA,
      S_PUSH,
      S_DONE
   } state_t;

   localparam logic [3:0] DEF_COUNT = 4'(NUM_ROWS);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        count_q, count_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        idx_q, idx_d;
   logic [ROW_W-1:0]  data_q, data_d;
   logic [3:0]        cnt_inc;

`ifdef FETCH_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
`endif

   assign cnt_inc = cnt_q + 4'd1;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      addr_d   = addr_q;
      count_d  = count_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      data_d   = data_q;
      avm_read = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wd_d     = wd_q;
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = cfg_base;
               addr_d  = cfg_base;
               count_d = (cfg_count == 4'd0) ? DEF_COUNT : cfg_count;
               cnt_d   = 4'd0;
`ifdef FETCH_TIMEOUT_EN
               err_d   = 1'b0;
`endif
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Strobe is gated by waitrequest so a stalled slave never sees a held read.
            if (!avm_waitrequest) begin
               avm_read = 1'b1;
`ifdef FETCH_TIMEOUT_EN
               wd_d     = '0;
`endif
               state_d  = S_WAIT_DATA;
            end
         end
         S_WAIT_DATA: begin
            if (avm_readdatavalid) begin
               data_d  = avm_readdata;
               idx_d   = cnt_q;
               state_d = S_PUSH;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end
         S_PUSH: begin
            if (row_ready) begin
               cnt_d = cnt_inc;
               if (cnt_inc == count_q) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = base_q + ADDR_W'(cnt_inc);
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         addr_q  <= '0;
         count_q <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
         wd_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
`ifdef FETCH_TIMEOUT_EN
         wd_q    <= wd_d;
         err_q   <= err_d;
`endif
      end
   end

   assign avm_address = addr_q;
   assign row_data    = data_q;
   assign row_idx     = idx_q;
   assign row_valid   = (state_q == S_PUSH);
   assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT_DATA) || (state_q == S_PUSH);
   assign done        = (state_q == S_DONE);
`ifdef FETCH_TIMEOUT_EN
   assign error       = err_q;
`else
   assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_row_fetcher.sv
// tb/tb_matrix_row_fetcher.sv - Directed self-checking bench for matrix_row_fetcher.
module tb_matrix_row_fetcher;

   localparam int LAT = 13;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] cfg_base;
   logic [3:0]  cfg_count;
   logic [31:0] avm_address;
   logic        avm_read;
   logic [63:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        avm_waitrequest;
   logic [63:0] row_data;
   logic [3:0]  row_idx;
   logic        row_valid;
   logic        row_ready;
   logic        busy;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   int          strobes = 0;
   int          done_cnt = 0;
   int          lat_cnt = 0;
   bit          prev_read = 0;
   bit          no_resp = 0;
   bit          stray_req = 0;
   logic [31:0] pend_addr = '0;
   logic [31:0] addr_log[$];
   logic [3:0]  idx_log[$];
   logic [63:0] data_log[$];

   matrix_row_fetcher dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .cfg_base          (cfg_base),
      .cfg_count         (cfg_count),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_waitrequest   (avm_waitrequest),
      .row_data          (row_data),
      .row_idx           (row_idx),
      .row_valid         (row_valid),
      .row_ready         (row_ready),
      .busy              (busy),
      .done              (done),
      .error             (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ROM slave: row r returns {8{r[7:0]}} LAT cycles after the strobe
   initial begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      forever begin
         @(negedge clk);
         avm_readdatavalid = 1'b0;
         if (!reset_n) begin
            lat_cnt   = 0;
            prev_read = 0;
         end else begin
            if (lat_cnt > 0) begin
               lat_cnt--;
               if (lat_cnt == 0) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata      = {8{pend_addr[7:0]}};
                  check("addr_held", avm_address, pend_addr);
               end
            end else if (stray_req) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = 64'hDEADBEEF_CAFEF00D;
               stray_req         = 0;
            end
            if (avm_read) begin
               check("read_gap", prev_read, 0);
               check("one_outstanding", lat_cnt, 0);
               strobes++;
               addr_log.push_back(avm_address);
               pend_addr = avm_address;
               if (!no_resp) lat_cnt = LAT;
            end
            prev_read = avm_read;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && row_valid && row_ready) begin
            idx_log.push_back(row_idx);
            data_log.push_back(row_data);
         end
         if (reset_n && done) begin
            done_cnt++;
            check("busy_at_done", busy, 0);
         end
      end
   end

   task automatic do_start(input logic [31:0] b, input logic [3:0] c);
      cfg_base  = b;
      cfg_count = c;
      start     = 1'b1;
      @(posedge clk); #2;
      start     = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int max);
      int n = 0;
      while (done_cnt == d0 && n < max) begin
         @(posedge clk); #2;
         n++;
      end
      check("done_in_time", n < max, 1);
   endtask

   task automatic clear_logs();
      addr_log.delete();
      idx_log.delete();
      data_log.delete();
   endtask

   task automatic check_run(input logic [31:0] b, input int n);
      logic [7:0] v;
      check("n_reads", addr_log.size(), n);
      check("n_rows", idx_log.size(), n);
      for (int i = 0; i < n; i++) begin
         v = b[7:0] + 8'(i);
         if (i < addr_log.size()) check("rd_addr", addr_log[i], b + 32'(i));
         if (i < idx_log.size()) begin
            check("row_idx", idx_log[i], 64'(i));
            check("row_data", data_log[i], {8{v}});
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_read"}, avm_read, 0);
      check({tag, "_addr"}, avm_address, 0);
      check({tag, "_valid"}, row_valid, 0);
      check({tag, "_data"}, row_data, 0);
      check({tag, "_idx"}, row_idx, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
   endtask

   initial begin
      int d0, s0, n;
      bit ok;
      logic [63:0] snap_d;
      logic [3:0]  snap_i;

      reset_n = 1'b0;
      start = 1'b0;
      cfg_base = '0;
      cfg_count = '0;
      avm_waitrequest = 1'b0;
      row_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_idle_outputs("reset");
      reset_n = 1'b1;
      @(posedge clk); #2;

      // nominal: 8 default rows, consumer always ready
      clear_logs();
      row_ready = 1'b1;
      d0 = done_cnt;
      do_start(32'd0, 4'd0);
      check("busy_after_start", busy, 1);
      wait_done(d0, 2000);
      check_run(32'd0, 8);
      check("nominal_done_once", done_cnt, d0 + 1);
      @(posedge clk); #2;
      check("nominal_idle_busy", busy, 0);

      // backpressure on row 3
      clear_logs();
      row_ready = 1'b0;
      d0 = done_cnt;
      do_start(32'd0, 4'd6);
      for (int r = 0; r < 6; r++) begin
         n = 0;
         while (!row_valid && n < 200) begin
            @(posedge clk); #2;
            n++;
         end
         check("bp_valid_in_time", n < 200, 1);
         if (r == 3) begin
            snap_d = row_data;
            snap_i = row_idx;
            s0 = strobes;
            ok = 1;
            repeat (20) begin
               @(posedge clk); #2;
               if (!row_valid || row_data !== snap_d || row_idx !== snap_i) ok = 0;
            end
            check("bp_stable", ok, 1);
            check("bp_no_read", strobes, s0);
         end
         row_ready = 1'b1;
         @(posedge clk); #2;
         row_ready = 1'b0;
      end
      wait_done(d0, 200);
      check_run(32'd0, 6);

      // waitrequest stall on a single-row run
      clear_logs();
      row_ready = 1'b1;
      avm_waitrequest = 1'b1;
      d0 = done_cnt;
      s0 = strobes;
      do_start(32'd2, 4'd1);
      ok = 1;
      repeat (5) begin
         if (avm_read !== 1'b0 || busy !== 1'b1) ok = 0;
         @(posedge clk); #2;
      end
      check("stall_no_read", ok, 1);
      check("stall_no_strobe", strobes, s0);
      avm_waitrequest = 1'b0;
      wait_done(d0, 200);
      check("stall_one_strobe", strobes, s0 + 1);
      check_run(32'd2, 1);

      // partial run with an ignored second start
      clear_logs();
      d0 = done_cnt;
      do_start(32'd5, 4'd3);
      repeat (20) @(posedge clk);
      #2;
      check("partial_busy_mid", busy, 1);
      do_start(32'd0, 4'd1);
      wait_done(d0, 500);
      check_run(32'd5, 3);
      s0 = strobes;
      repeat (10) @(posedge clk);
      #2;
      check("partial_no_rerun", strobes, s0);
      check("partial_single_done", done_cnt, d0 + 1);

      // stray readdatavalid while idle
      snap_d = row_data;
      stray_req = 1;
      repeat (3) @(posedge clk);
      #2;
      check("stray_valid", row_valid, 0);
      check("stray_data", row_data, snap_d);
      check("stray_busy", busy, 0);

      // asynchronous reset during WAIT_DATA of row 4
      clear_logs();
      d0 = done_cnt;
      s0 = strobes;
      do_start(32'd0, 4'd0);
      n = 0;
      while (strobes < s0 + 5 && n < 500) begin
         @(posedge clk); #2;
         n++;
      end
      check("row4_strobe_seen", n < 500, 1);
      repeat (3) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      @(posedge clk); #2;
      reset_n = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      check("midreset_no_done", done_cnt, d0);
      check("midreset_idle", busy, 0);
      clear_logs();
      do_start(32'd0, 4'd2);
      wait_done(d0, 500);
      check_run(32'd0, 2);

`ifdef FETCH_TIMEOUT_EN
      // watchdog: slave never answers
      clear_logs();
      no_resp = 1;
      d0 = done_cnt;
      do_start(32'd1, 4'd1);
      wait_done(d0, 300);
      check("to_error", error, 1);
      check("to_busy", busy, 0);
      check("to_no_row", idx_log.size(), 0);
      no_resp = 0;
      stray_req = 1;
      repeat (3) @(posedge clk);
      #2;
      check("to_late_ignored", row_valid, 0);
      check("to_error_sticky", error, 1);
      clear_logs();
      d0 = done_cnt;
      do_start(32'd1, 4'd1);
      check("to_error_cleared", error, 0);
      wait_done(d0, 300);
      check_run(32'd1, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
